edge_capture_mc: RTL
====================

EDGE_CAPTURE_MC -- requirements
Module: edge_capture_mc

Interface
REQ-001 Parameter N, default 8: number of independent input channels (1..32).
REQ-002 Parameter HW, default 8: width of hold_len.
REQ-003 Parameter CW, default 16: width of each per-channel event counter (used only with EDGE_CAPTURE_CNT_EN).
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 in  input  N: asynchronous channel inputs.
REQ-007 mode  input  2N: per-channel edge select, bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both.
REQ-008 ext_rst_en  input  1: H selects clear-by-clr, L selects clear-by-timer.
REQ-009 clr  input  1: H-active synchronous clear of all captured outputs.
REQ-010 hold_len  input  HW: timer-mode output hold length, in clk cycles.
REQ-011 out  output  N: H-active per-channel capture flags, registered.
REQ-012 any_out  output  1: registered OR of the next-state out vector, aligned with out.
REQ-013 edge_cnt  output  N*CW: per-channel event counters, present only with EDGE_CAPTURE_CNT_EN.

Function
REQ-014 Each in[i] passes through a 2-flop synchroniser (s1, s2); s3 holds the previous s2.
REQ-015 Edge condition: rising = s2 & !s3; falling = !s2 & s3; qualified by mode[i]; mode 00 never fires.
REQ-016 Latency: a level change sampled into s1 at edge k sets out[i] at edge k+2.
REQ-017 On a qualified edge, out[i] is set to 1 and the channel hold timer loads hold_len (0 treated as 1).
REQ-018 Timer mode (ext_rst_en=0): the timer decrements while out[i]=1; out[i] clears on the edge where the timer reaches 0, giving exactly max(hold_len,1) cycles high.
REQ-019 Timer mode: a qualified edge while out[i]=1 reloads the timer (retriggerable); out[i] does not drop.
REQ-020 Clear mode (ext_rst_en=1): out[i] stays 1 until a cycle with clr=1; the timer is ignored.
REQ-021 clr=1 and a qualified edge on the same channel in the same cycle: the edge wins, and out[i] is 1 on the next cycle.
REQ-022 clr in timer mode clears out[i] and the timer immediately.
REQ-023 A change of ext_rst_en while out[i]=1 takes effect from the next cycle; timer state is retained.
REQ-024 A change of mode during a hold does not affect the current hold; it qualifies subsequent edges only.
REQ-025 hold_len is sampled only at timer load.

Reset
REQ-026 While reset=1: s1, s2, s3, out, any_out, timers and counters are all 0.
REQ-027 Edge detection is suppressed for the first 3 cycles after reset deasserts (arm counter), so a static high input never produces a spurious rising edge.
REQ-028 reset asserted mid-hold clears out on the next edge, regardless of mode.

Configuration
REQ-029 Macro EDGE_CAPTURE_CNT_EN defined: each channel has a CW-bit saturating counter, incremented on every qualified edge (including retriggers) and cleared by reset or clr; when clr and an edge coincide, the counter loads 1; the counter holds at all-ones when saturated.
REQ-030 Macro EDGE_CAPTURE_CNT_EN undefined: there is no edge_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-031 Shared package edge_capture_pkg holds the mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the arm-delay constant (3).
REQ-032 Per-channel logic (synchroniser, detector, timer, counter) is a sub-module edge_capture_ch, instantiated N times by a generate loop; the arm counter and any_out are in the top level.

Verification
REQ-033 N=8, mode ch0=01, hold_len=4, ext_rst_en=0, in[0] rises -> out[0] high from sample edge+2 for exactly 4 cycles; any_out matches.
REQ-034 mode ch1=11, ext_rst_en=1, in[1] pulses high for 5 cycles -> out[1] set on the rise and held after the fall; clr at cycle 20 -> out[1]=0 at cycle 21.
REQ-035 Timer mode, hold_len=6, second rise 3 cycles into the hold -> out high 9 cycles total, no gap.
REQ-036 in held at all-ones through reset release -> out stays 0 for 10 cycles; mode 00 channel toggling -> never set.
REQ-037 clr and a qualified edge coincide on ch2 -> out[2]=1 next cycle; with EDGE_CAPTURE_CNT_EN, edge_cnt ch2=1.
REQ-038 CW=4, 20 edges with EDGE_CAPTURE_CNT_EN -> counter saturates at 15; reset -> 0.

Source files
------------

// File: rtl/edge_capture_pkg.sv
// edge_capture_pkg: shared encodings for the edge capture block.
//   mode_e   per-channel edge select (off / rising / falling / both)
//   ARM_DLY  post-reset cycles during which edge detection is held off
package edge_capture_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Covers the synchroniser fill after reset: s1, s2, s3 all carry live data.
  localparam logic [1:0] ARM_DLY = 2'd3;

endpackage

// File: rtl/edge_capture_ch.sv
// edge_capture_ch: one capture channel.
//   2-flop synchroniser (s1, s2) plus history flop s3, edge qualifier,
//   hold timer and capture flag. Optional saturating event counter when
//   EDGE_CAPTURE_CNT_EN is defined.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_i              asynchronous channel input
//   mode_i            edge select (mode_e encoding)
//   armed_i           edge detection enable from the top-level arm counter
//   ext_rst_en_i      1: clear by clr_i, 0: clear by timer
//   clr_i             synchronous clear of flag/timer/counter
//   hold_len_i        timer reload value (0 treated as 1)
//   out_o / out_d_o   registered capture flag / its next-state value
//   cnt_o             event counter (EDGE_CAPTURE_CNT_EN only)
module edge_capture_ch
  import edge_capture_pkg::*;
#(
  parameter int HW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_i,
  input  logic [1:0]    mode_i,
  input  logic          armed_i,
  input  logic          ext_rst_en_i,
  input  logic          clr_i,
  input  logic [HW-1:0] hold_len_i,
`ifdef EDGE_CAPTURE_CNT_EN
  output logic [CW-1:0] cnt_o,
`endif
  output logic          out_o,
  output logic          out_d_o
);

  logic          s1_q, s2_q, s3_q;
  logic          out_q, out_d;
  logic [HW-1:0] tmr_q, tmr_d;
  logic          rise, fall, hit;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
  assign hit  = armed_i & ((rise & (mode_i == MODE_RISE || mode_i == MODE_BOTH)) |
                           (fall & (mode_i == MODE_FALL || mode_i == MODE_BOTH)));

  // Priority: a qualified edge beats clr, clr beats timer expiry.
  // In clear mode the timer is frozen (not cleared) so a later switch back
  // to timer mode resumes the remaining hold.
  always_comb begin
    out_d = out_q;
    tmr_d = tmr_q;
    if (hit) begin
      out_d = 1'b1;
      tmr_d = (hold_len_i == '0) ? HW'(1) : hold_len_i;
    end else if (clr_i) begin
      out_d = 1'b0;
      tmr_d = '0;
    end else if (out_q && !ext_rst_en_i) begin
      if (tmr_q <= HW'(1)) begin
        out_d = 1'b0;
        tmr_d = '0;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      out_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      s1_q  <= in_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      out_q <= out_d;
      tmr_q <= tmr_d;
    end
  end

  assign out_o   = out_q;
  assign out_d_o = out_d;

`ifdef EDGE_CAPTURE_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  // A coinciding clr wipes the old count but the edge itself still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (hit)        cnt_d = clr_i ? CW'(1) : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    else if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/edge_capture_mc.sv
// edge_capture_mc: N-channel edge capture with timed or externally
// cleared hold.
// Optional feature macro: EDGE_CAPTURE_CNT_EN (adds edge_cnt counters).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in           asynchronous channel inputs [N]
//   mode         per-channel edge select, bits [2i+1:2i]
//   ext_rst_en   1: clear by clr, 0: clear by hold timer
//   clr          synchronous clear of captured outputs
//   hold_len     timer-mode hold length in cycles
//   out          registered per-channel capture flags
//   any_out      registered OR of next-state out (aligned with out)
//   edge_cnt     per-channel counters, CW bits each (EDGE_CAPTURE_CNT_EN)
module edge_capture_mc
  import edge_capture_pkg::*;
#(
  parameter int N  = 8,
  parameter int HW = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in,
  input  logic [2*N-1:0]  mode,
  input  logic            ext_rst_en,
  input  logic            clr,
  input  logic [HW-1:0]   hold_len,
`ifdef EDGE_CAPTURE_CNT_EN
  output logic [N*CW-1:0] edge_cnt,
`endif
  output logic [N-1:0]    out,
  output logic            any_out
);

  logic [1:0]   arm_q;
  logic         armed;
  logic [N-1:0] out_d;
  logic         any_q;

  // Hold off detection until the synchroniser holds post-reset samples only,
  // otherwise a static-high input looks like a rising edge.
  assign armed = (arm_q == ARM_DLY);

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q <= '0;
      any_q <= 1'b0;
    end else begin
      if (!armed) arm_q <= arm_q + 1'b1;
      any_q <= |out_d;
    end
  end

  assign any_out = any_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    edge_capture_ch #(.HW(HW), .CW(CW)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .in_i         (in[g]),
      .mode_i       (mode[2*g +: 2]),
      .armed_i      (armed),
      .ext_rst_en_i (ext_rst_en),
      .clr_i        (clr),
      .hold_len_i   (hold_len),
`ifdef EDGE_CAPTURE_CNT_EN
      .cnt_o        (edge_cnt[g*CW +: CW]),
`endif
      .out_o        (out[g]),
      .out_d_o      (out_d[g])
    );
  end

endmodule
